// File: rtl/gshare_pred_if.sv
// Predictor port bundle: IF/EX pipeline side is the master, the predictor the slave.
interface gshare_pred_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned HIST_W = 6
);
  logic [ADDR_W-1:0] addr_i;
  logic              if_fire;
  logic              br_p;
  logic [ADDR_W-1:0] addr_p;
  logic [HIST_W-1:0] hist_p;
  logic              ready;
  logic              is_br;
  logic [ADDR_W-1:0] addr_ex;
  logic [ADDR_W-1:0] jmp_addr;
  logic              jmp;
  logic [HIST_W-1:0] hist_ex;
  logic              mispred;

  modport master (
    output addr_i, if_fire, is_br, addr_ex, jmp_addr, jmp, hist_ex, mispred,
    input  br_p, addr_p, hist_p, ready
  );

  modport slave (
    input  addr_i, if_fire, is_br, addr_ex, jmp_addr, jmp, hist_ex, mispred,
    output br_p, addr_p, hist_p, ready
  );
endinterface

// File: rtl/gshare_pred.sv
// Gshare branch predictor: direct-mapped BTB plus PHT of saturating counters indexed by
// PC xor speculative global history. Tables are cleared by a post-reset sweep.
module gshare_pred #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned HIST_W    = 6,
  parameter int unsigned CNT_W     = 2
) (
  input logic          clk,
  input logic          rst,
  gshare_pred_if.slave bp
);

  localparam int unsigned TAG_W     = ADDR_W - BTB_IDX_W - 2;
  localparam int unsigned SWEEP_W   = (BTB_IDX_W > PHT_IDX_W) ? BTB_IDX_W : PHT_IDX_W;
  localparam int unsigned BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int unsigned PHT_DEPTH = 1 << PHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [SWEEP_W-1:0]  sweep_q, sweep_d;
  logic [HIST_W-1:0]   ghr_q, ghr_d;

  logic                btb_valid [BTB_DEPTH];
  logic [TAG_W-1:0]    btb_tag   [BTB_DEPTH];
  logic [ADDR_W-1:0]   btb_tgt   [BTB_DEPTH];
  logic [CNT_W-1:0]    pht       [PHT_DEPTH];

  logic                run;
  logic [BTB_IDX_W-1:0] lk_btb_idx, up_btb_idx, sw_btb_idx;
  logic [PHT_IDX_W-1:0] lk_pht_idx, up_pht_idx, sw_pht_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, lk_taken;
  logic                up_en;
  logic [CNT_W-1:0]    up_cnt, up_cnt_next;
  logic                sw_in_btb, sw_in_pht;
  logic                unused_addr_lsbs;

  assign run = (state_q == StRun);

  // Fetch-side lookup; everything is forced quiet outside RUN.
  assign lk_btb_idx = bp.addr_i[BTB_IDX_W+1:2];
  assign lk_tag     = bp.addr_i[ADDR_W-1:BTB_IDX_W+2];
  assign lk_pht_idx = bp.addr_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign lk_hit     = run & btb_valid[lk_btb_idx] & (btb_tag[lk_btb_idx] == lk_tag);
  assign lk_taken   = lk_hit & pht[lk_pht_idx][CNT_W-1];

  assign bp.br_p   = lk_taken;
  assign bp.addr_p = lk_taken ? btb_tgt[lk_btb_idx] : '0;
  assign bp.hist_p = ghr_q;
  assign bp.ready  = run;

  // Resolved-branch update uses the history snapshot that travelled with the branch.
  assign up_en      = run & bp.is_br;
  assign up_btb_idx = bp.addr_ex[BTB_IDX_W+1:2];
  assign up_tag     = bp.addr_ex[ADDR_W-1:BTB_IDX_W+2];
  assign up_pht_idx = bp.addr_ex[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bp.hist_ex);
  assign up_cnt     = pht[up_pht_idx];

  // Saturating counter step.
  always_comb begin
    up_cnt_next = up_cnt;
    if (bp.jmp) begin
      if (up_cnt != CNT_MAX) up_cnt_next = up_cnt + CNT_W'(1);
    end else begin
      if (up_cnt != '0) up_cnt_next = up_cnt - CNT_W'(1);
    end
  end

  // The sweep counter spans the larger table; the smaller table skips out-of-range steps.
  assign sw_btb_idx = sweep_q[BTB_IDX_W-1:0];
  assign sw_pht_idx = sweep_q[PHT_IDX_W-1:0];
  assign sw_in_btb  = (sweep_q >> BTB_IDX_W) == '0;
  assign sw_in_pht  = (sweep_q >> PHT_IDX_W) == '0;

  assign unused_addr_lsbs = ^{bp.addr_i[1:0], bp.addr_ex[1:0]};

  // Next state: sweep in INIT; in RUN, history recovery beats the speculative shift.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    case (state_q)
      StInit: begin
        sweep_d = sweep_q + SWEEP_W'(1);
        if (&sweep_q) state_d = StRun;
      end
      StRun: begin
        if (bp.is_br && bp.mispred) begin
          ghr_d = (bp.hist_ex << 1) | HIST_W'(bp.jmp);
        end else if (bp.if_fire && lk_hit) begin
          ghr_d = (ghr_q << 1) | HIST_W'(lk_taken);
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // BTB storage: cleared by the sweep, allocated only by taken branches.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      if (sw_in_btb) btb_valid[sw_btb_idx] <= 1'b0;
    end else if (up_en && bp.jmp) begin
      btb_valid[up_btb_idx] <= 1'b1;
      btb_tag[up_btb_idx]   <= up_tag;
      btb_tgt[up_btb_idx]   <= bp.jmp_addr;
    end
  end

  // PHT storage: initialised weakly-not-taken, trained by every resolved branch.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      if (sw_in_pht) pht[sw_pht_idx] <= CNT_WNT;
    end else if (up_en) begin
      pht[up_pht_idx] <= up_cnt_next;
    end
  end

endmodule

// File: tb/tb_gshare_pred.sv
// Bench for gshare_pred: expected predictions are queued as lookups are driven and
// compared once the combinational outputs settle.
module tb_gshare_pred;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gshare_pred_if #(.ADDR_W(32), .HIST_W(6)) bus ();

  gshare_pred #(
    .ADDR_W   (32),
    .BTB_IDX_W(6),
    .PHT_IDX_W(8),
    .HIST_W   (6),
    .CNT_W    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bus)
  );

  typedef struct {
    string       tag;
    logic        br;
    logic [31:0] addr;
    logic [5:0]  hist;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a lookup, queue what it must produce, then pop and compare after settling.
  task automatic expect_pred(input string tag, input logic [31:0] a, input logic br,
                             input logic [31:0] tgt, input logic [5:0] hist);
    exp_t e;
    bus.addr_i = a;
    e.tag = tag; e.br = br; e.addr = tgt; e.hist = hist;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_br_p"},   64'(bus.br_p),   64'(e.br));
      check_eq({e.tag, "_addr_p"}, 64'(bus.addr_p), 64'(e.addr));
      check_eq({e.tag, "_hist_p"}, 64'(bus.hist_p), 64'(e.hist));
    end
  endtask

  task automatic br_update(input logic [31:0] a, input logic [31:0] tgt, input logic j,
                           input logic [5:0] h, input logic mp);
    bus.is_br    = 1'b1;
    bus.addr_ex  = a;
    bus.jmp_addr = tgt;
    bus.jmp      = j;
    bus.hist_ex  = h;
    bus.mispred  = mp;
    step();
    bus.is_br   = 1'b0;
    bus.mispred = 1'b0;
  endtask

  // Count cycles until ready while hammering is_br/mispred; br_p must stay low.
  task automatic sweep_check(input string tag);
    int n = 0;
    bit brp_seen = 1'b0;
    bus.is_br    = 1'b1;
    bus.mispred  = 1'b1;
    bus.jmp      = 1'b1;
    bus.addr_ex  = 32'h1000;
    bus.jmp_addr = 32'h2000;
    bus.hist_ex  = 6'b101010;
    while (!bus.ready && n < 1000) begin
      bus.addr_i = $urandom;
      #1;
      if (bus.br_p) brp_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.is_br   = 1'b0;
    bus.mispred = 1'b0;
    check_eq({tag, "_len"}, 64'(n), 64'd256);
    check_eq({tag, "_brp_quiet"}, 64'(brp_seen), 64'd0);
    check_eq({tag, "_ghr_untouched"}, 64'(bus.hist_p), 64'd0);
  endtask

  initial begin
    bus.addr_i = '0; bus.if_fire = 1'b0; bus.is_br = 1'b0; bus.addr_ex = '0;
    bus.jmp_addr = '0; bus.jmp = 1'b0; bus.hist_ex = '0; bus.mispred = 1'b0;

    // Reset and sweep
    repeat (3) @(posedge clk);
    #1;
    expect_pred("rst", 32'h1000, 1'b0, 32'h0, 6'd0);
    check_eq("rst_ready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    sweep_check("sweep1");
    expect_pred("init_ignored", 32'h1000, 1'b0, 32'h0, 6'd0);

    // Training: 01 -> 10 -> 01 -> 00, then 00 -> 01 stays not-taken
    br_update(32'h1000, 32'h2000, 1'b1, 6'd0, 1'b0);
    expect_pred("train_t1", 32'h1000, 1'b1, 32'h2000, 6'd0);
    br_update(32'h1000, 32'h2000, 1'b0, 6'd0, 1'b0);
    expect_pred("train_nt1", 32'h1000, 1'b0, 32'h0, 6'd0);
    br_update(32'h1000, 32'h2000, 1'b0, 6'd0, 1'b0);
    expect_pred("train_nt2", 32'h1000, 1'b0, 32'h0, 6'd0);
    br_update(32'h1000, 32'h2000, 1'b1, 6'd0, 1'b0);
    expect_pred("train_from00", 32'h1000, 1'b0, 32'h0, 6'd0);

    // Saturation: 01 -> 10 -> 11 (hold x3) -> 10 -> 01
    for (int i = 0; i < 5; i++) begin
      br_update(32'h1000, 32'h2000, 1'b1, 6'd0, 1'b0);
      expect_pred("sat_t", 32'h1000, 1'b1, 32'h2000, 6'd0);
    end
    br_update(32'h1000, 32'h2000, 1'b0, 6'd0, 1'b0);
    expect_pred("sat_nt1", 32'h1000, 1'b1, 32'h2000, 6'd0);
    br_update(32'h1000, 32'h2000, 1'b0, 6'd0, 1'b0);
    expect_pred("sat_nt2", 32'h1000, 1'b0, 32'h0, 6'd0);

    // History: train PHT entries 0,1,3,7 for 0x1000 so each fire predicts taken
    for (int k = 0; k < 4; k++) begin
      logic [5:0] h;
      h = 6'((1 << k) - 1);
      br_update(32'h1000, 32'h2000, 1'b1, h, 1'b0);
      br_update(32'h1000, 32'h2000, 1'b1, h, 1'b0);
    end
    bus.if_fire = 1'b1;
    expect_pred("hist0", 32'h1000, 1'b1, 32'h2000, 6'b000000);
    step();
    expect_pred("hist1", 32'h1000, 1'b1, 32'h2000, 6'b000001);
    step();
    expect_pred("hist2", 32'h1000, 1'b1, 32'h2000, 6'b000011);
    step();
    expect_pred("hist3", 32'h1000, 1'b1, 32'h2000, 6'b000111);
    // Recovery wins over the concurrent fire
    br_update(32'h1000, 32'h2000, 1'b0, 6'b000011, 1'b1);
    bus.if_fire = 1'b0;
    expect_pred("recover", 32'h1000, 1'b0, 32'h0, 6'b000110);
    br_update(32'h1000, 32'h2000, 1'b0, 6'd0, 1'b1);
    expect_pred("ghr_clear", 32'h1000, 1'b1, 32'h2000, 6'd0);

    // Aliasing: 0x1100 shares BTB index 0; the same-cycle lookup still sees the old entry
    br_update(32'h1000, 32'h2000, 1'b1, 6'd0, 1'b0);
    bus.is_br = 1'b1; bus.addr_ex = 32'h1100; bus.jmp_addr = 32'h3000;
    bus.jmp = 1'b1; bus.hist_ex = 6'd0;
    expect_pred("rw_same_cycle", 32'h1100, 1'b0, 32'h0, 6'd0);
    step();
    bus.is_br = 1'b0;
    expect_pred("alias_new", 32'h1100, 1'b1, 32'h3000, 6'd0);
    expect_pred("alias_old", 32'h1000, 1'b0, 32'h0, 6'd0);

    // A miss does not shift history
    bus.addr_i = 32'h1000;
    bus.if_fire = 1'b1;
    step();
    bus.if_fire = 1'b0;
    expect_pred("miss_noshift", 32'h1000, 1'b0, 32'h0, 6'd0);

    // Async reset mid-run: train index 0x41 so the post-fire lookup predicts taken
    br_update(32'h1100, 32'h3000, 1'b1, 6'd1, 1'b0);
    bus.addr_i = 32'h1100;
    bus.if_fire = 1'b1;
    step();
    bus.if_fire = 1'b0;
    expect_pred("pre_rst", 32'h1100, 1'b1, 32'h3000, 6'd1);
    #1;
    rst = 1'b0;
    expect_pred("rst_async", 32'h1100, 1'b0, 32'h0, 6'd0);
    check_eq("rst_async_ready", 64'(bus.ready), 64'd0);
    step();
    step();
    rst = 1'b1;
    sweep_check("sweep2");
    expect_pred("post_rst", 32'h1100, 1'b0, 32'h0, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
